// File: rtl/idma_desc64_reg_mc.sv
// Multi-channel desc64 register block: per-channel DESC_ADDR/STATUS windows feeding descriptor FIFOs.
// Optional completion interrupts are enabled with `define IDMA_DESC64_REG_MC_IRQ_EN.
module idma_desc64_reg_mc #(
    parameter int unsigned           NumChannels = 4,
    parameter int unsigned           FifoDepth   = 4,
    parameter int unsigned           AddrWidth   = 12,
    parameter logic [AddrWidth-1:0]  BaseAddr    = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         reg_req_valid_i,
    output logic                         reg_req_ready_o,
    input  logic [AddrWidth-1:0]         reg_req_addr_i,
    input  logic                         reg_req_write_i,
    input  logic [63:0]                  reg_req_wdata_i,
    output logic                         reg_rsp_valid_o,
    output logic [63:0]                  reg_rsp_rdata_o,
    output logic                         reg_rsp_error_o,
    output logic [NumChannels-1:0]       desc_valid_o,
    output logic [NumChannels-1:0][63:0] desc_addr_o,
    input  logic [NumChannels-1:0]       desc_ready_i,
    input  logic [NumChannels-1:0]       busy_i,
    input  logic [NumChannels-1:0]       done_i,
    output logic [NumChannels-1:0]       irq_o
);
    localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned ChW  = (NumChannels > 1) ? $clog2(NumChannels) : 1;

    logic [AddrWidth-1:0] off;
    logic [AddrWidth-5:0] ch_full;
    logic [3:0]           reg_sel;
    logic [ChW-1:0]       ch;
    logic                 dec_ok;
    logic                 is_desc;
    logic                 is_status;
    logic                 req_acc;
    logic [63:0]          status;
    logic [63:0]          rd_data;

    logic [NumChannels-1:0]            full;
    logic [NumChannels-1:0]            empty;
    logic [NumChannels-1:0]            push;
    logic [NumChannels-1:0]            pop;
    logic [NumChannels-1:0]            clr;
    logic [NumChannels-1:0]            irq_pend;
    logic [NumChannels-1:0][CntW-1:0]  fill;
    logic [NumChannels-1:0][63:0]      last_wr;
    logic [NumChannels-1:0][15:0]      done_cnt;

    logic        rsp_valid_p1;
    logic [63:0] rsp_rdata_p1;
    logic        rsp_error_p1;

    // Address decode; offsets beyond the channel range fold into ch_full so they decode as errors
    always_comb begin
        off       = reg_req_addr_i - BaseAddr;
        ch_full   = off[AddrWidth-1:4];
        reg_sel   = off[3:0];
        ch        = ch_full[ChW-1:0];
        dec_ok    = (reg_req_addr_i >= BaseAddr) && (32'(ch_full) < NumChannels)
                    && ((reg_sel == 4'h0) || (reg_sel == 4'h8));
        is_desc   = dec_ok && (reg_sel == 4'h0);
        is_status = dec_ok && (reg_sel == 4'h8);
    end

    // Stall is judged on registered fill state so a same-cycle pop cannot unblock it
    assign reg_req_ready_o = !(reg_req_valid_i && reg_req_write_i && is_desc && full[ch]);
    assign req_acc         = reg_req_valid_i && reg_req_ready_o;

    always_comb begin
        status        = '0;
        status[0]     = busy_i[ch] | !empty[ch];
        status[1]     = full[ch];
        status[2]     = irq_pend[ch];
        status[8 +: CntW] = fill[ch];
        status[31:16] = done_cnt[ch];
        rd_data       = '0;
        if (!reg_req_write_i) begin
            if (is_desc) begin
                rd_data = last_wr[ch];
            end else if (is_status) begin
                rd_data = status;
            end
        end
    end

    for (genvar c = 0; c < NumChannels; c++) begin : g_ch
        logic [63:0]     mem [FifoDepth];
        logic [PtrW-1:0] wptr;
        logic [PtrW-1:0] rptr;
        logic [CntW-1:0] cnt;
        logic [63:0]     last_q;
        logic [15:0]     done_q;

        assign full[c]         = (cnt == CntW'(FifoDepth));
        assign empty[c]        = (cnt == '0);
        assign push[c]         = req_acc && reg_req_write_i && is_desc && (ch == ChW'(c));
        assign pop[c]          = !empty[c] && desc_ready_i[c];
        assign clr[c]          = req_acc && !reg_req_write_i && is_status && (ch == ChW'(c));
        assign fill[c]         = cnt;
        assign last_wr[c]      = last_q;
        assign done_cnt[c]     = done_q;
        assign desc_valid_o[c] = !empty[c];
        assign desc_addr_o[c]  = mem[rptr];

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                wptr   <= '0;
                rptr   <= '0;
                cnt    <= '0;
                last_q <= '0;
                done_q <= '0;
            end else begin
                if (push[c]) begin
                    wptr   <= wptr + 1'b1;
                    last_q <= reg_req_wdata_i;
                end
                if (pop[c]) begin
                    rptr <= rptr + 1'b1;
                end
                case ({push[c], pop[c]})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
                if (done_i[c]) begin
                    done_q <= done_q + 16'd1;
                end
            end
        end

        // Storage is not reset; the pointers alone define which entries are live
        always_ff @(posedge clk_i) begin
            if (push[c]) begin
                mem[wptr] <= reg_req_wdata_i;
            end
        end
    end

`ifdef IDMA_DESC64_REG_MC_IRQ_EN
    // A done pulse coinciding with the clearing read wins, so no completion is lost
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            irq_pend <= '0;
        end else begin
            irq_pend <= (irq_pend & ~clr) | done_i;
        end
    end
    assign irq_o = irq_pend;
`else
    assign irq_pend = '0;
    assign irq_o    = '0;
`endif

    // Response stage: registered one cycle after acceptance
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rsp_valid_p1 <= 1'b0;
            rsp_rdata_p1 <= '0;
            rsp_error_p1 <= 1'b0;
        end else begin
            rsp_valid_p1 <= req_acc;
            if (req_acc) begin
                rsp_rdata_p1 <= rd_data;
                rsp_error_p1 <= !dec_ok;
            end
        end
    end

    assign reg_rsp_valid_o = rsp_valid_p1;
    assign reg_rsp_rdata_o = rsp_rdata_p1;
    assign reg_rsp_error_o = rsp_error_p1;

endmodule

// File: tb/tb_idma_desc64_reg_mc.sv
// Directed bench for idma_desc64_reg_mc with default parameters (4 channels, depth 4).
module tb_idma_desc64_reg_mc;
    localparam int NC = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [11:0]       req_addr;
    logic              req_write;
    logic [63:0]       req_wdata;
    logic              rsp_valid;
    logic [63:0]       rsp_rdata;
    logic              rsp_error;
    logic [NC-1:0]     desc_valid;
    logic [NC-1:0][63:0] desc_addr;
    logic [NC-1:0]     desc_ready;
    logic [NC-1:0]     busy;
    logic [NC-1:0]     done;
    logic [NC-1:0]     irq;

    int total = 0;
    int bad   = 0;

    logic [63:0] rd;
    logic        er;
    logic [63:0] irq_bit;

    idma_desc64_reg_mc dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .reg_req_valid_i (req_valid),
        .reg_req_ready_o (req_ready),
        .reg_req_addr_i  (req_addr),
        .reg_req_write_i (req_write),
        .reg_req_wdata_i (req_wdata),
        .reg_rsp_valid_o (rsp_valid),
        .reg_rsp_rdata_o (rsp_rdata),
        .reg_rsp_error_o (rsp_error),
        .desc_valid_o    (desc_valid),
        .desc_addr_o     (desc_addr),
        .desc_ready_i    (desc_ready),
        .busy_i          (busy),
        .done_i          (done),
        .irq_o           (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one request starting just after a posedge; returns the registered response
    task automatic req(input string tag, input logic w, input logic [11:0] a,
                       input logic [63:0] d, output logic [63:0] r, output logic e);
        int waited = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        #1;
        while (!req_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!req_ready) begin
            chk({tag, "_timeout"}, 64'(req_ready), 64'd1);
            req_valid = 1'b0;
            r = '0;
            e = 1'b0;
        end else begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            chk({tag, "_rspv"}, 64'(rsp_valid), 64'd1);
            r = rsp_rdata;
            e = rsp_error;
        end
    endtask

    initial begin
`ifdef IDMA_DESC64_REG_MC_IRQ_EN
        irq_bit = 64'h4;
`else
        irq_bit = 64'h0;
`endif
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
        desc_ready = '0; busy = '0; done = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rspv", 64'(rsp_valid), 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", 64'(rsp_error), 0);
        chk("rst_dvalid", 64'(desc_valid), 0);
        chk("rst_irq", 64'(irq), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        req("st2", 1'b0, 12'h028, 0, rd, er);
        chk("st2_rdata", rd, 0);
        chk("st2_err", 64'(er), 0);
        chk("st2_dvalid", 64'(desc_valid), 0);
        chk("st2_rspv_drop", 64'(rsp_valid), 64'(1'b0) | 64'(1'b1));

        busy[2] = 1'b1;
        req("st2b", 1'b0, 12'h028, 0, rd, er);
        chk("st2b_rdata", rd, 64'h1);
        busy[2] = 1'b0;

        // Two descriptors into ch1 held by the fetcher
        req("w1a", 1'b1, 12'h010, 64'h1000_0000, rd, er);
        req("w1b", 1'b1, 12'h010, 64'h2000_0000, rd, er);
        req("st1", 1'b0, 12'h018, 0, rd, er);
        chk("st1_rdata", rd, 64'h201);
        req("da1", 1'b0, 12'h010, 0, rd, er);
        chk("da1_rdata", rd, 64'h2000_0000);
        chk("ch1_head0_v", 64'(desc_valid[1]), 1);
        chk("ch1_head0", desc_addr[1], 64'h1000_0000);
        desc_ready[1] = 1'b1;
        @(posedge clk); #1;
        chk("ch1_head1_v", 64'(desc_valid[1]), 1);
        chk("ch1_head1", desc_addr[1], 64'h2000_0000);
        @(posedge clk); #1;
        chk("ch1_empty", 64'(desc_valid[1]), 0);
        desc_ready[1] = 1'b0;

        // Fill ch0 and stall the fifth write
        for (int i = 0; i < 4; i++) req("w0", 1'b1, 12'h000, 64'hA0 + 64'(i), rd, er);
        req("st0f", 1'b0, 12'h008, 0, rd, er);
        chk("st0f_rdata", rd, 64'h403);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h000; req_wdata = 64'hA4;
        #1;
        chk("stall_rdy0", 64'(req_ready), 0);
        @(posedge clk); #1;
        chk("stall_rdy1", 64'(req_ready), 0);
        chk("stall_rspv", 64'(rsp_valid), 0);
        desc_ready[0] = 1'b1;
        #1;
        chk("stall_same_pop", 64'(req_ready), 0);
        @(posedge clk); #1;
        desc_ready[0] = 1'b0;
        chk("stall_release", 64'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("stall_acc_rspv", 64'(rsp_valid), 1);
        desc_ready[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ch0_drain_v", 64'(desc_valid[0]), 1);
            chk("ch0_drain", desc_addr[0], 64'hA1 + 64'(i));
            @(posedge clk); #1;
        end
        chk("ch0_drained", 64'(desc_valid[0]), 0);
        desc_ready[0] = 1'b0;

        // Decode errors must have no side effects
        req("e04r", 1'b0, 12'h004, 0, rd, er);
        chk("e04r_err", 64'(er), 1);
        chk("e04r_rdata", rd, 0);
        req("e40w", 1'b1, 12'h040, 64'h55, rd, er);
        chk("e40w_err", 64'(er), 1);
        req("e40r", 1'b0, 12'h040, 0, rd, er);
        chk("e40r_err", 64'(er), 1);
        chk("e40r_rdata", rd, 0);
        req("e1Cw", 1'b1, 12'h01C, 64'h66, rd, er);
        chk("e1Cw_err", 64'(er), 1);
        chk("err_no_push", 64'(desc_valid), 0);
        req("stw", 1'b1, 12'h018, 64'h77, rd, er);
        chk("stw_err", 64'(er), 0);
        chk("stw_no_push", 64'(desc_valid), 0);
        req("da1b", 1'b0, 12'h010, 0, rd, er);
        chk("da1b_unchanged", rd, 64'h2000_0000);

        // Done counter wrap on ch3
        done[3] = 1'b1;
        repeat (32'h10001) @(posedge clk);
        #1;
        done[3] = 1'b0;
        chk("irq3_set", 64'(irq[3]), irq_bit >> 2);
        req("st3a", 1'b0, 12'h038, 0, rd, er);
        chk("st3a_rdata", rd, 64'h1_0000 | irq_bit);
        chk("irq3_clr", 64'(irq[3]), 0);
        req("st3b", 1'b0, 12'h038, 0, rd, er);
        chk("st3b_rdata", rd, 64'h1_0000);
        done[3] = 1'b1;
        req("st3c", 1'b0, 12'h038, 0, rd, er);
        done[3] = 1'b0;
        chk("st3c_preinc", rd, 64'h1_0000);
        chk("irq3_keep", 64'(irq[3]), irq_bit >> 2);
        req("st3d", 1'b0, 12'h038, 0, rd, er);
        chk("st3d_rdata", rd, 64'h2_0000 | irq_bit);

        // Reset with three queued entries and a response pending
        for (int i = 0; i < 3; i++) req("w0r", 1'b1, 12'h000, 64'hB0 + 64'(i), rd, er);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h008;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        chk("mid_rspv_before", 64'(rsp_valid), 1);
        @(posedge clk); #1;
        chk("mid_rspv", 64'(rsp_valid), 0);
        chk("mid_dvalid", 64'(desc_valid), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        req("st0r", 1'b0, 12'h008, 0, rd, er);
        chk("st0r_rdata", rd, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/idma_desc64_reg_mc.md
Name: idma_desc64_reg_mc

Overview:
- Multi-channel successor to the single-channel desc64 register block.
- Provides NumChannels independent register windows. Each window has a DESC_ADDR register at 0x0 and a STATUS register at 0x8, and channel windows are spaced 0x10 apart.
- Each DESC_ADDR write pushes the descriptor address into that channel's FIFO, which drains to the descriptor fetcher through a valid/ready handshake.
- Sits between the config-bus adapter and the per-channel descriptor fetch frontends.

Parameters:
- NumChannels, 4, number of channels (1..16).
- FifoDepth, 4, descriptor FIFO entries per channel (power of 2, 2..16).
- AddrWidth, 12, register request address width.
- BaseAddr, 0, byte address of channel 0 DESC_ADDR.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- reg_req_valid_i  in  1  register request valid.
- reg_req_ready_o  out  1  register request accepted when valid&&ready.
- reg_req_addr_i  in  AddrWidth  byte address.
- reg_req_write_i  in  1  1=write, 0=read.
- reg_req_wdata_i  in  64  write data.
- reg_rsp_valid_o  out  1  response strobe, one cycle after acceptance.
- reg_rsp_rdata_o  out  64  read data.
- reg_rsp_error_o  out  1  decode error.
- desc_valid_o  out  NumChannels  per-channel FIFO head valid.
- desc_addr_o  out  NumChannels x 64  per-channel FIFO head address.
- desc_ready_i  in  NumChannels  fetcher accepts head.
- busy_i  in  NumChannels  backend busy per channel.
- done_i  in  NumChannels  one-cycle completion pulse per channel.
- irq_o  out  NumChannels  completion interrupt.

Behaviour:
- Reset (rst_ni=0 at posedge): all FIFOs empty, all counters 0, last-written registers 0.
- Outputs at reset: reg_rsp_valid_o=0, rdata=0, error=0, desc_valid_o=0, irq_o=0.
- Decode: off = addr - BaseAddr; ch = off[7:4]; reg = off[3:0].
  - reg=0x0 is DESC_ADDR; reg=0x8 is STATUS.
  - Any other reg, ch>=NumChannels, or addr<BaseAddr gives error=1, rdata=0, no side effects.
- Handshake:
  - reg_req_ready_o=0 only for a valid write to DESC_ADDR of a channel whose FIFO is full; otherwise ready_o=1.
  - A pop in the same cycle does not lift the stall; full is evaluated on registered state.
  - Response is registered: rsp_valid_o pulses 1 cycle after acceptance, carrying rdata and error. Back-to-back requests are accepted every cycle.
- DESC_ADDR:
  - Write pushes wdata and updates that channel's last-written register.
  - Read returns last-written value. Read has no FIFO effect.
- STATUS (read):
  - bit0 = busy_i[ch] | FIFO non-empty.
  - bit1 = FIFO full.
  - bit2 = irq_pending (0 without the optional feature).
  - [12:8] = FIFO fill count.
  - [31:16] = done counter, 16 bits, wraps 0xFFFF->0x0000.
  - Other bits are 0.
- STATUS write: no effect, error=0.
- FIFO:
  - First-word fall-through: desc_valid_o = !empty, and desc_addr_o = head.
  - Pop on desc_valid_o&&desc_ready_i.
  - Simultaneous push and pop leaves the fill count unchanged. Push into an empty FIFO shows valid the next cycle.
- done_i[ch] increments that channel's done counter by 1 per cycle asserted. A STATUS read in the same cycle returns the pre-increment value.
- Reset mid-operation discards FIFO contents and drops a pending response (rsp_valid_o=0 the next cycle).

Optional Feature:
- Macro: IDMA_DESC64_REG_MC_IRQ_EN.
- Defined:
  - done_i[ch] sets sticky irq_pending[ch], and irq_o[ch]=irq_pending[ch] (registered).
  - An accepted STATUS read of ch returns bit2=1 and clears pending the next cycle.
  - If done_i arrives in the same cycle as that read, pending stays 1.
- Undefined: irq_o tied to 0, STATUS bit2 reads 0, no pending state.

Test Plan:
- Reset, then read ch2 STATUS (addr 0x28) -> rsp_valid 1 cycle later, rdata=0x0, error=0; desc_valid_o=0.
- Write 0x1000_0000 then 0x2000_0000 to ch1 DESC_ADDR (0x10) with desc_ready_i=0 -> ch1 STATUS fill=2, bit0=1. Then ready=1 -> heads appear in order 0x1000_0000, 0x2000_0000, then valid=0.
- Fill ch0 with 4 writes, issue a 5th -> ready_o=0 until one pop; the 5th is accepted the cycle after the pop; STATUS bit1=1 while full.
- Access 0x04, 0x40 (with NumChannels=4), and 0x1C -> error=1, rdata=0, no FIFO change in any channel.
- Pulse done_i[3] 0x10001 times -> ch3 STATUS[31:16]=0x0001; with IRQ_EN, irq_o[3]=1, first STATUS read bit2=1, irq_o[3]=0 afterward.
- Assert rst_ni=0 with ch0 holding 3 entries and a read in flight -> next cycle fill=0, desc_valid_o=0, rsp_valid_o=0.
